// File: rtl/reg_bank_dump.sv
// Sequential reader that walks a register bank and streams each word out over valid/ready.
// Optional DUMP_CHECKSUM_EN adds a running modular sum of accepted words on port checksum.
module reg_bank_dump #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d = '0;
          state_d   = FETCH;
`ifdef DUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      FETCH: begin
        out_data_d  = rd_data;
        out_index_d = rd_addr_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          csum_d      = csum_q + out_data_q;
`endif
          if (rd_addr_q == LAST) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
    // Abort overrides any handshake decided above, so that word is neither counted nor summed.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      rd_addr_d   = '0;
`ifdef DUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DUMP_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_reg_bank_dump.sv
// Scoreboard bench for reg_bank_dump: expected words queued at start, popped on each handshake.
// Build with DUMP_CHECKSUM_EN defined to also cover the checksum port.
module tb_reg_bank_dump;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;
  logic [AW-1:0] rd_addr, out_index;
  logic [DW-1:0] rd_data, out_data;
  logic out_valid, busy, done;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] bank [DEPTH];
  logic [AW+DW-1:0] sb [$];
  logic [AW+DW-1:0] exp_w;
  int checks = 0;
  int errors = 0;
  int words = 0;

  always #5 clk = ~clk;
  assign rd_data = bank[rd_addr];

  reg_bank_dump #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
`ifdef DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Inputs change 1 time unit after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !abort) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_word: got idx=%0d data=%h, required no word", out_index, out_data);
      end else begin
        exp_w = sb.pop_front();
        if ({out_index, out_data} !== exp_w) begin
          errors++;
          $display("FAIL sb_word: got idx=%0d data=%h, required idx=%0d data=%h",
                   out_index, out_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
      words++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_ramp();
    for (int i = 0; i < DEPTH; i++) bank[i] = DW'(i * 3);
  endtask

  task automatic kick(input logic with_abort);
    sb.delete();
    words = 0;
    for (int i = 0; i < DEPTH; i++) sb.push_back({AW'(i), bank[i]});
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_index(input logic [AW-1:0] idx, output logic ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_index == idx) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_to_idle(input int c0, output int done_cyc, output int ndone, output int idle_cyc);
    done_cyc = -1;
    ndone = 0;
    idle_cyc = -1;
    for (int c = c0 + 1; c <= c0 + 300; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, done, out_index, rd_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b idx=%0d a=%0d data=%h, required all zero",
               out_valid, busy, done, out_index, rd_addr, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_full_dump();
    int dc, nd, ic;
    load_ramp();
    kick(1'b0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_e0: valid=%b busy=%b, required 0 1", out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL full_first: valid=%b idx=%0d data=%h, required 1 0 0", out_valid, out_index, out_data);
    end
    run_to_idle(1, dc, nd, ic);
    checks++;
    if (dc != 64 || nd != 1 || ic != 65) begin
      errors++;
      $display("FAIL full_done: done_cyc=%0d n=%0d idle_cyc=%0d, required 64 1 65", dc, nd, ic);
    end
    checks++;
    if (words != 32 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_count: words=%0d left=%0d, required 32 0", words, sb.size());
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd1488) begin
      errors++;
      $display("FAIL full_checksum: got %h, required %h", checksum, 32'd1488);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic ok;
    int n, dc, nd, ic;
    load_ramp();
    bank[7] = 32'hDEADBEEF;
    kick(1'b0);
    wait_index(5'd7, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_reach: index 7 not seen, required seen"); end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_index, out_data} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d v=%b idx=%0d data=%h, required 1 7 deadbeef",
                 k, out_valid, out_index, out_data);
      end
    end
    checks++;
    if (words != 7) begin errors++; $display("FAIL bp_words: got %0d, required 7", words); end
    out_ready = 1'b1;
    run_to_idle(0, dc, nd, ic);
    checks++;
    if (nd != 1 || words != 32 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_end: ndone=%0d words=%0d left=%0d, required 1 32 0", nd, words, sb.size());
    end
  endtask

  task automatic test_abort();
    logic ok;
    int n, dc, nd, ic;
    load_ramp();
    kick(1'b0);
    wait_index(5'd10, ok, n);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (!ok || out_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== 0) begin
      errors++;
      $display("FAIL abort_idle: seen=%b v=%b busy=%b addr=%0d, required 1 0 0 0", ok, out_valid, busy, rd_addr);
    end
    checks++;
    if (words != 10 || sb.size() != 22) begin
      errors++;
      $display("FAIL abort_count: words=%0d left=%0d, required 10 22", words, sb.size());
    end
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL abort_nodone: done seen %0d times, required 0", nd); end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd135) begin
      errors++;
      $display("FAIL abort_checksum: got %h, required %h", checksum, 32'd135);
    end
`endif
    kick(1'b0);
    run_to_idle(0, dc, nd, ic);
    checks++;
    if (nd != 1 || words != 32 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: ndone=%0d words=%0d left=%0d, required 1 32 0", nd, words, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n, dc, nd, ic;
    load_ramp();
    kick(1'b0);
    wait_index(5'd20, ok, n);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {out_valid, busy, done, out_index, rd_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid: seen=%b v=%b b=%b idx=%0d a=%0d data=%h, required 1 and all zero",
               ok, out_valid, busy, out_index, rd_addr, out_data);
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin errors++; $display("FAIL rst_checksum: got %h, required 0", checksum); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_release: busy=%b, required 0", busy); end
    kick(1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 0) begin
      errors++;
      $display("FAIL rst_restart: v=%b idx=%0d, required 1 0", out_valid, out_index);
    end
    run_to_idle(1, dc, nd, ic);
    checks++;
    if (nd != 1 || words != 32 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_full: ndone=%0d words=%0d left=%0d, required 1 32 0", nd, words, sb.size());
    end
  endtask

  task automatic test_start_busy();
    logic ok;
    int n, dc, nd, ic;
    load_ramp();
    bank[31] = 32'hFFFFFFFF;
    kick(1'b0);
    wait_index(5'd3, ok, n);
    checks++;
    if (!ok || n != 7) begin errors++; $display("FAIL sb_idx3: seen=%b at cycle %0d, required 1 7", ok, n); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_to_idle(n + 1, dc, nd, ic);
    checks++;
    if (dc != 64 || nd != 1 || words != 32 || sb.size() != 0) begin
      errors++;
      $display("FAIL busy_start: done_cyc=%0d n=%0d words=%0d left=%0d, required 64 1 32 0",
               dc, nd, words, sb.size());
    end
    checks++;
    if (rd_addr !== 5'd31 || out_index !== 5'd31 || out_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL last_word: addr=%0d idx=%0d data=%h, required 31 31 ffffffff", rd_addr, out_index, out_data);
    end
    kick(1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_abort_idle: busy=%b, required 1", busy); end
    run_to_idle(0, dc, nd, ic);
    checks++;
    if (nd != 1 || words != 32) begin
      errors++;
      $display("FAIL start_abort_run: ndone=%0d words=%0d, required 1 32", nd, words);
    end
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int dc, nd, ic;
    for (int i = 0; i < DEPTH; i++) bank[i] = 32'h10000000;
    kick(1'b0);
    run_to_idle(0, dc, nd, ic);
    checks++;
    if (checksum !== 32'h00000000 || nd != 1) begin
      errors++;
      $display("FAIL csum_wrap: got %h ndone=%0d, required 00000000 1", checksum, nd);
    end
    for (int i = 0; i < DEPTH; i++) bank[i] = 32'd1;
    kick(1'b0);
    run_to_idle(0, dc, nd, ic);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (checksum !== 32'd32) begin
      errors++;
      $display("FAIL csum_ones: got %h, required %h", checksum, 32'd32);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_start_busy();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
